// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and defaults for the two-way round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2
    } arb_state_e;

    localparam int ARB_MAX_HOLD_DEFAULT = 8;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/arb2_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : arb2_rr_arbiter_if
// Description : req/gnt bundle between the two clients and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface arb2_rr_arbiter_if #(
    parameter int CNT_W = 4
);
    logic             req_0;
    logic             req_1;
    logic             gnt_0;
    logic             gnt_1;
    logic             preempt;
    logic [CNT_W-1:0] hold_cnt;

    // Client side: drives requests, observes grants.
    modport master (
        output req_0, req_1,
        input  gnt_0, gnt_1, preempt, hold_cnt
    );

    // Arbiter side: observes requests, drives grants.
    modport slave (
        input  req_0, req_1,
        output gnt_0, gnt_1, preempt, hold_cnt
    );
endinterface : arb2_rr_arbiter_if
`default_nettype wire

// File: rtl/arb_hold_ctr.sv
`default_nettype none
// ============================================================================
// Module      : arb_hold_ctr
// Description : Saturating hold-time counter (load-to-1, clear, increment).
// Revision    : 1.0 - initial release
// ============================================================================
module arb_hold_ctr #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load1,
    input  wire logic             clr,
    input  wire logic             en,
    output logic      [CNT_W-1:0] cnt,
    output logic                  sat
);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load1) begin
            r_cnt <= C_ONE;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != C_MAX)) begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

    assign cnt = r_cnt;
    assign sat = (r_cnt == C_MAX);

endmodule : arb_hold_ctr
`default_nettype wire

// File: rtl/arb2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : arb2_rr_arbiter
// Description : Two-requester round-robin arbiter, registered exclusive grants
//               with timeout pre-emption under contention.
// Revision    : 1.0 - initial release
// ============================================================================
module arb2_rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  wire logic   clk,
    input  wire logic   reset,
    arb2_rr_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE = ARB_IDLE;
    localparam logic [1:0] S_GNT0 = ARB_GNT0;
    localparam logic [1:0] S_GNT1 = ARB_GNT1;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic             r_last_owner;
    logic             r_gnt_0;
    logic             r_gnt_1;
    logic             r_preempt;
    logic             w_preempt;
    logic             w_load1;
    logic             w_clr;
    logic             w_en;
    logic             w_sat;
    logic [CNT_W-1:0] w_cnt;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req_0 && bus.req_1) begin
                    w_next = r_last_owner ? S_GNT0 : S_GNT1;
                end else if (bus.req_0) begin
                    w_next = S_GNT0;
                end else if (bus.req_1) begin
                    w_next = S_GNT1;
                end
            end
            S_GNT0: begin
                if (!bus.req_0) begin
                    w_next = bus.req_1 ? S_GNT1 : S_IDLE;
                end else if (bus.req_1 && w_sat) begin
                    w_next = S_GNT1;
                end
            end
            S_GNT1: begin
                if (!bus.req_1) begin
                    w_next = bus.req_0 ? S_GNT0 : S_IDLE;
                end else if (bus.req_0 && w_sat) begin
                    w_next = S_GNT0;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // A switch while the current owner still requests can only be a timeout.
    assign w_preempt = ((r_state == S_GNT0) && (w_next == S_GNT1) && bus.req_0) ||
                       ((r_state == S_GNT1) && (w_next == S_GNT0) && bus.req_1);

    assign w_load1 = (w_next != S_IDLE) && (w_next != r_state);
    assign w_clr   = (w_next == S_IDLE);
    assign w_en    = (w_next != S_IDLE) && (w_next == r_state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_owner <= 1'b1;
            r_gnt_0      <= 1'b0;
            r_gnt_1      <= 1'b0;
            r_preempt    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_gnt_0   <= (w_next == S_GNT0);
            r_gnt_1   <= (w_next == S_GNT1);
            r_preempt <= w_preempt;
            if (w_load1) begin
                r_last_owner <= (w_next == S_GNT1);
            end
        end
    end

    arb_hold_ctr #(
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (CNT_W)
    ) u_hold_ctr (
        .clk   (clk),
        .reset (reset),
        .load1 (w_load1),
        .clr   (w_clr),
        .en    (w_en),
        .cnt   (w_cnt),
        .sat   (w_sat)
    );

    assign bus.gnt_0    = r_gnt_0;
    assign bus.gnt_1    = r_gnt_1;
    assign bus.preempt  = r_preempt;
    assign bus.hold_cnt = w_cnt;

endmodule : arb2_rr_arbiter
`default_nettype wire
